// File: rtl/stereo_frame_buffer_pkg.sv
// Shared constants for the stereo frame buffer and its clients: FSM encodings,
// image select values and the default image geometry.
package stereo_frame_buffer_pkg;

    localparam int DEF_WIDTH  = 20;
    localparam int DEF_HEIGHT = 7;

    typedef enum logic [1:0] {
        BIDLE = 2'b00,
        FILL  = 2'b01,
        READY = 2'b10
    } buf_state_t;

    localparam logic IMG_LEFT  = 1'b0;
    localparam logic IMG_RIGHT = 1'b1;

endpackage

// File: rtl/stereo_frame_buffer_frame_ram.sv
// Single-write-port, single-read-port synchronous RAM holding one image.
// Contents are intentionally not reset.
module frame_ram #(
    parameter int DEPTH  = 140,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/stereo_frame_buffer.sv
// Two-image pixel store: raster writes for left/right images, coordinate reads
// with one-cycle latency, and a FILL/READY handshake with the disparity engine.
module stereo_frame_buffer
    import stereo_frame_buffer_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int DATA_W  = 8,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    input  logic               wr_sel,
    input  logic               wr_sof,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [COORD_W-1:0] buffer_href,
    input  logic [COORD_W-1:0] buffer_vref,
    input  logic               image_sel,
    input  logic               frame_release,
    output logic [DATA_W-1:0]  image_data,
    output logic               buffer_ready,
    output logic               left_done,
    output logic               right_done,
    output logic               overflow,
    output logic [1:0]         buf_state
);

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AFW   = 2 * COORD_W;

    buf_state_t        state_r;
    logic [CW-1:0]     cnt_l_r;
    logic [CW-1:0]     cnt_r_r;
    logic              rd_valid_r;
    logic              rd_sel_r;

    logic              sel_done_s;
    logic [CW-1:0]     sel_cnt_s;
    logic              wr_accept_s;
    logic [AW-1:0]     wr_addr_s;
    logic              wr_last_s;
    logic              left_done_nx_s;
    logic              right_done_nx_s;
    logic              we_l_s;
    logic              we_r_s;
    logic [AFW-1:0]    rd_addr_full_s;
    logic              rd_in_range_s;
    logic [AW-1:0]     rd_addr_s;
    logic [DATA_W-1:0] rdata_l_s;
    logic [DATA_W-1:0] rdata_r_s;

    // Write acceptance, target address and next done flags.
    always_comb begin
        sel_done_s = left_done;
        sel_cnt_s  = cnt_l_r;
        if (wr_sel == IMG_RIGHT) begin
            sel_done_s = right_done;
            sel_cnt_s  = cnt_r_r;
        end else begin
            sel_done_s = left_done;
            sel_cnt_s  = cnt_l_r;
        end

        wr_accept_s = 1'b0;
        if (wr_valid && (state_r == FILL)) begin
            if (wr_sof) begin
                wr_accept_s = 1'b1;
            end else if (!sel_done_s && (sel_cnt_s < CW'(DEPTH))) begin
                wr_accept_s = 1'b1;
            end else begin
                wr_accept_s = 1'b0;
            end
        end else begin
            wr_accept_s = 1'b0;
        end

        wr_addr_s = wr_sof ? {AW{1'b0}} : sel_cnt_s[AW-1:0];
        wr_last_s = wr_accept_s && (wr_addr_s == AW'(DEPTH - 1));

        left_done_nx_s  = left_done;
        right_done_nx_s = right_done;
        if (wr_accept_s && (wr_sel == IMG_LEFT)) begin
            if (wr_last_s) begin
                left_done_nx_s = 1'b1;
            end else if (wr_sof) begin
                left_done_nx_s = 1'b0;
            end else begin
                left_done_nx_s = left_done;
            end
        end else if (wr_accept_s) begin
            if (wr_last_s) begin
                right_done_nx_s = 1'b1;
            end else if (wr_sof) begin
                right_done_nx_s = 1'b0;
            end else begin
                right_done_nx_s = right_done;
            end
        end else begin
            left_done_nx_s  = left_done;
            right_done_nx_s = right_done;
        end
    end

    assign we_l_s = wr_accept_s && (wr_sel == IMG_LEFT);
    assign we_r_s = wr_accept_s && (wr_sel == IMG_RIGHT);

    // Full-width address so large coordinates cannot alias into range.
    assign rd_addr_full_s = AFW'(WIDTH) * AFW'(buffer_vref) + AFW'(buffer_href);
    assign rd_in_range_s  = (AFW'(buffer_href) < AFW'(WIDTH)) &&
                            (AFW'(buffer_vref) < AFW'(HEIGHT));
    assign rd_addr_s      = rd_in_range_s ? rd_addr_full_s[AW-1:0] : {AW{1'b0}};

    frame_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_ram_left (
        .clk   (clk),
        .we    (we_l_s),
        .waddr (wr_addr_s),
        .wdata (wr_data),
        .raddr (rd_addr_s),
        .rdata (rdata_l_s)
    );

    frame_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_ram_right (
        .clk   (clk),
        .we    (we_r_s),
        .waddr (wr_addr_s),
        .wdata (wr_data),
        .raddr (rd_addr_s),
        .rdata (rdata_r_s)
    );

    // Read-side qualifiers aligned with the RAM output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            rd_sel_r   <= IMG_LEFT;
        end else begin
            rd_valid_r <= rd_in_range_s;
            rd_sel_r   <= image_sel;
        end
    end

    assign image_data = !rd_valid_r ? {DATA_W{1'b0}} :
                        (rd_sel_r == IMG_RIGHT) ? rdata_r_s : rdata_l_s;

    // Buffer FSM with its counters and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= BIDLE;
            buffer_ready <= 1'b0;
            left_done    <= 1'b0;
            right_done   <= 1'b0;
            overflow     <= 1'b0;
            cnt_l_r      <= {CW{1'b0}};
            cnt_r_r      <= {CW{1'b0}};
        end else begin
            if (wr_valid && !wr_accept_s) begin
                overflow <= 1'b1;
            end
            case (state_r)
                BIDLE: begin
                    state_r <= FILL;
                end
                FILL: begin
                    left_done  <= left_done_nx_s;
                    right_done <= right_done_nx_s;
                    if (we_l_s) begin
                        cnt_l_r <= wr_sof ? CW'(1) : cnt_l_r + CW'(1);
                    end
                    if (we_r_s) begin
                        cnt_r_r <= wr_sof ? CW'(1) : cnt_r_r + CW'(1);
                    end
                    // Look ahead so buffer_ready rises together with the last done flag.
                    if (left_done_nx_s && right_done_nx_s) begin
                        state_r      <= READY;
                        buffer_ready <= 1'b1;
                    end
                end
                READY: begin
                    if (frame_release) begin
                        state_r      <= FILL;
                        buffer_ready <= 1'b0;
                        left_done    <= 1'b0;
                        right_done   <= 1'b0;
                        cnt_l_r      <= {CW{1'b0}};
                        cnt_r_r      <= {CW{1'b0}};
                    end
                end
                default: begin
                    state_r      <= BIDLE;
                    buffer_ready <= 1'b0;
                end
            endcase
        end
    end

    assign buf_state = state_r;

endmodule

// File: tb/tb_stereo_frame_buffer.sv
// Directed bench for stereo_frame_buffer: fills, table-driven readback,
// READY write blocking, release, excess pixels and reset mid-fill.
module tb_stereo_frame_buffer;
    import stereo_frame_buffer_pkg::*;

    localparam int W = DEF_WIDTH;
    localparam int H = DEF_HEIGHT;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_sel = 1'b0;
    logic       wr_sof = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [9:0] buffer_href = 10'd0;
    logic [9:0] buffer_vref = 10'd0;
    logic       image_sel = 1'b0;
    logic       frame_release = 1'b0;
    logic [7:0] image_data;
    logic       buffer_ready;
    logic       left_done;
    logic       right_done;
    logic       overflow;
    logic [1:0] buf_state;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int         href;
        int         vref;
        logic       sel;
        logic [7:0] exp;
        string      name;
    } rd_vec_t;

    rd_vec_t rd_tab [10];

    stereo_frame_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_sel        (wr_sel),
        .wr_sof        (wr_sof),
        .wr_data       (wr_data),
        .buffer_href   (buffer_href),
        .buffer_vref   (buffer_vref),
        .image_sel     (image_sel),
        .frame_release (frame_release),
        .image_data    (image_data),
        .buffer_ready  (buffer_ready),
        .left_done     (left_done),
        .right_done    (right_done),
        .overflow      (overflow),
        .buf_state     (buf_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wr_px(input logic sel, input logic sof, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_sof   = sof;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
    endtask

    task automatic rd_px(input int h, input int v, input logic sel, output logic [7:0] d);
        buffer_href = 10'(h);
        buffer_vref = 10'(v);
        image_sel   = sel;
        tick();
        d = image_data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] d;

        rd_tab[0] = '{2, 3, 1'b1, 8'(255 - 62), "rd_r_2_3"};
        rd_tab[1] = '{2, 3, 1'b0, 8'd62, "rd_l_2_3"};
        rd_tab[2] = '{20, 0, 1'b0, 8'h00, "oor_href"};
        rd_tab[3] = '{0, 7, 1'b1, 8'h00, "oor_vref"};
        rd_tab[4] = '{19, 6, 1'b0, 8'd139, "rd_l_last"};
        rd_tab[5] = '{19, 6, 1'b1, 8'(255 - 139), "rd_r_last"};
        rd_tab[6] = '{0, 0, 1'b0, 8'h00, "rd_l_first"};
        rd_tab[7] = '{0, 0, 1'b1, 8'hFF, "rd_r_first"};
        rd_tab[8] = '{3, 13, 1'b0, 8'h00, "oor_alias"};
        rd_tab[9] = '{5, 1, 1'b1, 8'(255 - 25), "rd_r_5_1"};

        // Reset values
        tick();
        tick();
        chk("rst_state", buf_state, 2'b00);
        chk("rst_data", image_data, 0);
        chk("rst_ready", buffer_ready, 0);
        chk("rst_ldone", left_done, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;
        tick();
        chk("idle_to_fill", buf_state, 2'b01);

        // Left fill
        for (int a = 0; a < N; a++) begin
            wr_px(IMG_LEFT, a == 0, 8'(a));
            if (a == N - 2) chk("ldone_early", left_done, 0);
        end
        chk("ldone", left_done, 1);
        chk("ready_after_left", buffer_ready, 0);

        // Right fill
        for (int a = 0; a < N; a++) begin
            wr_px(IMG_RIGHT, a == 0, 8'(255 - a));
            if (a == N - 2) chk("ready_early", buffer_ready, 0);
        end
        chk("ready", buffer_ready, 1);
        chk("rdone", right_done, 1);
        chk("state_ready", buf_state, 2'b10);
        chk("ovf_clean", overflow, 0);

        // Table-driven readback, including out-of-range coordinates
        foreach (rd_tab[i]) begin
            rd_px(rd_tab[i].href, rd_tab[i].vref, rd_tab[i].sel, d);
            chk(rd_tab[i].name, d, rd_tab[i].exp);
        end
        rd_px(0, 0, 1'b0, d);
        chk("oor_no_side_effect", d, 0);

        // sof write while READY is dropped
        wr_px(IMG_LEFT, 1'b1, 8'h55);
        chk("ready_wr_ovf", overflow, 1);
        chk("ready_wr_state", buf_state, 2'b10);
        rd_px(0, 0, 1'b0, d);
        chk("ready_wr_kept", d, 0);

        // Release
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
        chk("rel_state", buf_state, 2'b01);
        chk("rel_ready", buffer_ready, 0);
        chk("rel_ldone", left_done, 0);
        chk("rel_rdone", right_done, 0);
        chk("rel_ovf_sticky", overflow, 1);

        // Reset mid-fill, then full fill with a release pulse in FILL
        do_reset();
        chk("rst2_ovf", overflow, 0);
        for (int a = 0; a < 50; a++) wr_px(IMG_LEFT, a == 0, 8'hEE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst3_state", buf_state, 2'b00);
        tick();
        for (int a = 0; a < N; a++) begin
            wr_px(IMG_LEFT, a == 0, 8'(a + 7));
            if (a == 89) chk("no_done_at_90", left_done, 0);
            if (a == 70) begin
                frame_release = 1'b1;
                tick();
                frame_release = 1'b0;
                chk("rel_in_fill", buf_state, 2'b01);
            end
            if (a == N - 2) chk("ldone_early2", left_done, 0);
        end
        chk("ldone_140", left_done, 1);
        chk("ready_left_only", buffer_ready, 0);
        chk("ovf_before_excess", overflow, 0);

        // Excess pixel during FILL
        wr_px(IMG_LEFT, 1'b0, 8'hAA);
        chk("excess_ovf", overflow, 1);
        rd_px(0, 0, 1'b0, d);
        chk("refill_first", d, 7);
        rd_px(19, 6, 1'b0, d);
        chk("refill_last", d, 139 + 7);
        rd_px(2, 3, 1'b1, d);
        chk("right_kept", d, 255 - 62);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
